// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counting timer: FSM encodings, register offsets, CTRL fields, bus bases.
// Combinational helpers only; no state and no handshakes.
package tc_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [31:0] TC0_BASE = 32'h0000_7f00;
  localparam logic [31:0] TC1_BASE = 32'h0000_7f10;

  // CTRL keeps only four bits; the rest of the word always reads as zero.
  function automatic logic [31:0] ctrl_word(input logic [3:0] ctrl);
    return {28'd0, ctrl};
  endfunction

endpackage

// File: rtl/timer_counter.sv
// 32-bit memory-mapped down-counting timer with one-shot and auto-reload modes plus a maskable level IRQ.
// Read data and IRQ are combinational (zero latency); writes always win over counting, stalling the FSM for that cycle.
module timer_counter
  import tc_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irq_q;
  tc_state_e   state_q;

  logic [1:0]  offset;
  logic        enable;
  logic [1:0]  mode;
  logic        count_last_d;
  logic [31:0] count_dec_d;
  logic        unused_addr;

  assign offset       = Addr[3:2];
  assign unused_addr  = ^Addr[31:4];
  assign enable       = ctrl_q[CTRL_EN];
  assign mode         = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
  // A COUNT of 0 or 1 both terminate, so the counter never wraps below zero.
  assign count_last_d = (count_q <= 32'd1);
  assign count_dec_d  = count_q - 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      irq_q    <= 1'b0;
      state_q  <= ST_IDLE;
    end else if (WE) begin
      case (offset)
        OFF_CTRL:   ctrl_q   <= Din[3:0];
        OFF_PRESET: preset_q <= Din;
        default:    ;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            irq_q   <= 1'b0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count_q <= preset_q;
          state_q <= ST_CNT;
        end
        ST_CNT: begin
          if (!enable) begin
            state_q <= ST_IDLE;
          end else if (!count_last_d) begin
            count_q <= count_dec_d;
          end else begin
            count_q <= 32'd0;
            irq_q   <= 1'b1;
            state_q <= ST_INT;
          end
        end
        ST_INT: begin
          // One-shot parks with the flag held until software re-enables; auto-reload drops it after one cycle.
          if (mode == 2'd0) begin
            ctrl_q[CTRL_EN] <= 1'b0;
          end else begin
            irq_q <= 1'b0;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (offset)
      OFF_CTRL:   Dout = ctrl_word(ctrl_q);
      OFF_PRESET: Dout = preset_q;
      OFF_COUNT:  Dout = count_q;
      default:    Dout = 32'd0;
    endcase
  end

  assign IRQ = ctrl_q[CTRL_IM] & irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed plus randomized bench for timer_counter; a phase-arithmetic reference model predicts every register read and IRQ.
module tb_timer_counter;
  import tc_defs::*;

  logic        clk;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int vectors;
  int miscompares;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an activation is described by the number of non-write
  // edges since it began (m_k) and the preset captured at load time; COUNT is
  // derived arithmetically from those two numbers.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_irq;
  logic        m_active;
  longint      m_k;
  longint      m_pl;

  function automatic longint term_k();
    return 2 + ((m_pl < 1) ? 1 : m_pl);
  endfunction

  task automatic m_edge(input logic r, input logic we, input logic [1:0] off, input logic [31:0] din);
    if (r) begin
      m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
      m_irq = 1'b0; m_active = 1'b0; m_k = 0; m_pl = 0;
    end else if (we) begin
      if (off == 2'd0) m_ctrl = din[3:0];
      else if (off == 2'd1) m_preset = din;
    end else if (!m_active) begin
      if (m_ctrl[0]) begin
        m_active = 1'b1; m_k = 1; m_irq = 1'b0;
      end
    end else if (m_k == 1) begin
      m_pl = longint'(m_preset); m_k = 2; m_count = m_preset;
    end else if (m_k == term_k()) begin
      if (m_ctrl[2:1] == 2'd0) m_ctrl[0] = 1'b0;
      else m_irq = 1'b0;
      m_active = 1'b0;
    end else if (!m_ctrl[0]) begin
      m_active = 1'b0;
    end else begin
      m_k++;
      m_count = (m_k - 2 >= m_pl) ? 32'd0 : 32'(m_pl - (m_k - 2));
      if (m_k == term_k()) m_irq = 1'b1;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] off);
    case (off)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_off(input logic [1:0] off);
    logic [31:0] full;
    full = TC0_BASE | {28'd0, off, 2'b00};
    Addr = full[31:2];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] off);
    set_off(off);
    #1;
    chk($sformatf("%s_off%0d", tag, off), Dout, m_read(off));
  endtask

  task automatic chk_irq(input string tag);
    chk($sformatf("%s_irq", tag), {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_irq});
  endtask

  task automatic chk_all(input string tag);
    for (int o = 0; o < 4; o++) chk_rd(tag, 2'(o));
    chk_irq(tag);
  endtask

  // One clock edge with the given inputs; returns 1ns after the edge with bus idle.
  task automatic cyc(input logic r, input logic we, input logic [1:0] off, input logic [31:0] din);
    reset = r; WE = we; set_off(off); Din = din;
    @(posedge clk);
    m_edge(r, we, off, din);
    #1;
    reset = 1'b0; WE = 1'b0; Din = 32'd0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] din);
    cyc(1'b0, 1'b1, off, din);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, OFF_COUNT, 32'd0);
      chk_rd(tag, OFF_COUNT);
      chk_irq(tag);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; WE = 1'b0; Din = 32'd0; set_off(2'd0);
    m_edge(1'b1, 1'b0, 2'd0, 32'd0);

    // Reset
    cyc(1'b1, 1'b0, 2'd0, 32'd0);
    cyc(1'b1, 1'b0, 2'd0, 32'd0);
    chk_all("reset");

    // One-shot, PRESET=5
    wr(OFF_PRESET, 32'd5);
    wr(OFF_CTRL, 32'h9);
    idle(7, "oneshot_count");
    chk_rd("oneshot_done", OFF_COUNT);
    chk("oneshot_count0", Dout, 32'd0);
    chk("oneshot_irq", {31'd0, IRQ}, 32'd1);
    idle(1, "oneshot_int");
    chk_rd("oneshot_ctrl", OFF_CTRL);
    chk("oneshot_ctrl8", Dout, 32'h8);
    idle(20, "oneshot_hold");
    wr(OFF_CTRL, 32'h9);
    chk_irq("oneshot_rewrite");
    idle(1, "oneshot_clear");
    chk("oneshot_irq_drop", {31'd0, IRQ}, 32'd0);
    wr(OFF_CTRL, 32'h0);
    idle(4, "oneshot_stop");

    // Auto-reload, PRESET=3
    wr(OFF_PRESET, 32'd3);
    wr(OFF_CTRL, 32'hB);
    idle(24, "reload");
    wr(OFF_CTRL, 32'h0);
    idle(4, "reload_stop");

    // PRESET edges 0 and 1
    for (int p = 0; p < 2; p++) begin
      wr(OFF_PRESET, 32'(p));
      wr(OFF_CTRL, 32'h9);
      idle(3, $sformatf("edge_p%0d", p));
      chk_rd("edge_nowrap", OFF_COUNT);
      chk("edge_count0", Dout, 32'd0);
      idle(3, "edge_tail");
      wr(OFF_CTRL, 32'h0);
      idle(2, "edge_stop");
    end

    // Masked one-shot
    wr(OFF_PRESET, 32'd2);
    wr(OFF_CTRL, 32'h1);
    idle(8, "masked");
    chk_all("masked_end");
    chk("masked_ctrl", m_read(OFF_CTRL), 32'h0);

    // Write contention during count
    wr(OFF_PRESET, 32'd10);
    wr(OFF_CTRL, 32'h9);
    idle(4, "contend_run");
    for (int i = 0; i < 4; i++) begin
      wr(OFF_PRESET, 32'd100 + 32'(i));
      chk_all("contend_wr");
      idle(1, "contend_gap");
    end
    wr(OFF_COUNT, 32'hDEAD_BEEF);
    chk_all("count_ro");
    wr(OFF_RSVD, 32'hFFFF_FFFF);
    chk_all("rsvd");
    wr(OFF_CTRL, 32'h0);
    idle(3, "contend_stop");

    // Disable mid-count at COUNT=4, then re-enable
    wr(OFF_PRESET, 32'd8);
    wr(OFF_CTRL, 32'h9);
    for (int i = 0; i < 40 && m_count != 32'd4; i++) idle(1, "dis_wait");
    chk_rd("dis_at4", OFF_COUNT);
    chk("dis_at4_val", Dout, 32'd4);
    wr(OFF_CTRL, 32'h8);
    idle(6, "dis_frozen");
    chk_rd("dis_frozen4", OFF_COUNT);
    chk("dis_frozen_val", Dout, 32'd4);
    wr(OFF_CTRL, 32'h9);
    idle(2, "dis_reload");
    chk_rd("dis_reload8", OFF_COUNT);
    chk("dis_reload_val", Dout, 32'd8);
    idle(10, "dis_finish");

    // Randomized traffic, including occasional mid-operation reset
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic        we;
      logic [1:0]  off;
      logic [31:0] din;
      r   = ($urandom_range(0, 249) == 0);
      we  = ($urandom_range(0, 7) == 0);
      off = 2'($urandom_range(0, 3));
      case (off)
        2'd0:    din = {$urandom_range(0, 15) == 0 ? 28'($urandom) : 28'd0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0)};
        2'd1:    din = 32'($urandom_range(0, 6));
        default: din = $urandom;
      endcase
      cyc(r, we, off, din);
      chk_rd("rand", 2'($urandom_range(0, 3)));
      chk_irq("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
